// File: rtl/alu_pipe_mc.sv
// alu_pipe_mc: registered 8-op ALU with valid/ready handshake and registered flags.
// Define ALU_MUL_EN to build op 111 as a WIDTH-cycle shift-add multiplier.
module alu_pipe_mc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       ZNO
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] out_q, out_d;
    logic [2:0]       zno_q, zno_d;
    logic             vld_q, vld_d;

    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res;
    logic             res_v;

    assign sub   = (op == 3'b001);
    assign bx    = sub ? ~Bin : Bin;
    assign sum   = {1'b0, Ain} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    assign shamt = Bin[SHW-1:0];

    always_comb begin
        res   = '0;
        res_v = 1'b0;
        case (op)
            3'b000, 3'b001: begin
                res   = sum[WIDTH-1:0];
                // carry into the MSB differs from carry out on signed overflow
                res_v = (Ain[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
            end
            3'b010:  res = Ain & Bin;
            3'b011:  res = ~Bin;
            3'b100:  res = Ain << shamt;
            3'b101:  res = $unsigned($signed(Ain) >>> shamt);
            3'b110:  res = Ain ^ Bin;
            default: begin
                res   = '0;
                res_v = 1'b0;
            end
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_nxt;

    assign in_ready = (state_q == IDLE);
    assign acc_nxt  = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        zno_d   = zno_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == 3'b111) begin
                        state_d = MUL;
                        cnt_d   = '0;
                        acc_d   = '0;
                        a_d     = {{WIDTH{1'b0}}, Ain};
                        b_d     = Bin;
                    end else begin
                        out_d = res;
                        zno_d = {res == '0, res[WIDTH-1], res_v};
                        vld_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = acc_nxt;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    out_d   = acc_nxt[WIDTH-1:0];
                    zno_d   = {acc_nxt[WIDTH-1:0] == '0, acc_nxt[WIDTH-1],
                               |acc_nxt[2*WIDTH-1:WIDTH]};
                    vld_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
`else
    assign in_ready = 1'b1;

    always_comb begin
        out_d = out_q;
        zno_d = zno_q;
        vld_d = in_valid;
        if (in_valid) begin
            out_d = res;
            zno_d = {res == '0, res[WIDTH-1], res_v};
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            zno_q <= 3'b000;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            zno_q <= zno_d;
            vld_q <= vld_d;
        end
    end

    assign out       = out_q;
    assign ZNO       = zno_q;
    assign out_valid = vld_q;
endmodule

// File: tb/tb_alu_pipe_mc.sv
// tb_alu_pipe_mc: vector table, hand-written corner sequences and a
// randomized cycle model check for alu_pipe_mc at WIDTH=16.
`timescale 1ns/1ps
module tb_alu_pipe_mc;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] Ain, Bin;
    logic         out_valid;
    logic [W-1:0] out;
    logic [2:0]   ZNO;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_pipe_mc #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .Ain      (Ain),
        .Bin      (Bin),
        .out_valid(out_valid),
        .out      (out),
        .ZNO      (ZNO)
    );

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eout;
        logic [2:0]   ezno;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed arithmetic on wide integers, flags from the result.
    function automatic logic [W+2:0] ref_alu(input logic [2:0] o,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa, sb, r, maxv, minv;
        logic [W-1:0] res;
        logic v;
        int sh;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        sh   = int'(b) % W;
        res  = '0;
        v    = 1'b0;
        case (o)
            3'd0: begin
                r = sa + sb;
                v = (r > maxv) || (r < minv);
                res = W'(r);
            end
            3'd1: begin
                r = sa - sb;
                v = (r > maxv) || (r < minv);
                res = W'(r);
            end
            3'd2: res = a & b;
            3'd3: res = ~b;
            3'd4: res = a << sh;
            3'd5: res = W'(sa >>> sh);
            3'd6: res = a ^ b;
            default: res = '0;
        endcase
        return {res, res == '0, res[W-1], v};
    endfunction

    task automatic drive(input logic v, input logic [2:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = v;
        op = o;
        Ain = a;
        Bin = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef ALU_MUL_EN
    task automatic mul_seq(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eo, input logic [2:0] ez,
                           input logic [W-1:0] po, input logic [2:0] pz,
                           input logic hold_add);
        drive(1'b1, 3'd7, a, b);
        tick();
        if (hold_add) drive(1'b1, 3'd0, 16'h0001, 16'h0001);
        else          drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < W; i++) begin
            check($sformatf("mul_busy_ready[%0d]", i), in_ready, 1'b0);
            check($sformatf("mul_busy_valid[%0d]", i), out_valid, 1'b0);
            check($sformatf("mul_busy_out[%0d]", i), out, po);
            check($sformatf("mul_busy_zno[%0d]", i), ZNO, pz);
            tick();
        end
        check("mul_done_valid", out_valid, 1'b1);
        check("mul_done_out", out, eo);
        check("mul_done_zno", ZNO, ez);
        check("mul_done_ready", in_ready, 1'b1);
        if (hold_add) begin
            tick();
            check("held_add_valid", out_valid, 1'b1);
            check("held_add_out", out, 16'h0002);
            check("held_add_zno", ZNO, 3'b000);
        end
        drive(1'b0, 3'd0, '0, '0);
    endtask
`endif

    logic [W+2:0]   r;
    logic [2*W-1:0] p;
    int             mul_left;
    logic [W-1:0]   m_out, pend_out;
    logic [2:0]     m_zno, pend_zno;
    logic           m_vld;

    initial begin
        vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b011};
        vecs[1]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 3'b100};
        vecs[2]  = '{3'd5, 16'h8000, 16'h0003, 16'hF000, 3'b010};
        vecs[3]  = '{3'd4, 16'h0001, 16'h000F, 16'h8000, 3'b010};
        vecs[4]  = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b100};
        vecs[5]  = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 3'b000};
        vecs[6]  = '{3'd3, 16'h0000, 16'h00FF, 16'hFF00, 3'b010};
        vecs[7]  = '{3'd1, 16'h8000, 16'h0001, 16'h7FFF, 3'b001};
        vecs[8]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b100};
        vecs[9]  = '{3'd4, 16'h1234, 16'h0014, 16'h2340, 3'b000};
        vecs[10] = '{3'd5, 16'h4000, 16'h0011, 16'h2000, 3'b000};
        vecs[11] = '{3'd0, 16'h8000, 16'h8000, 16'h0000, 3'b101};

        reset = 1'b0;
        drive(1'b0, 3'd0, '0, '0);
        #2 reset = 1'b1;
        #1;
        check("rst_out", out, 16'h0000);
        check("rst_zno", ZNO, 3'b000);
        check("rst_valid", out_valid, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_valid", out_valid, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            check($sformatf("vec_out[%0d]", i), out, vecs[i].eout);
            check($sformatf("vec_zno[%0d]", i), ZNO, vecs[i].ezno);
            check($sformatf("vec_valid[%0d]", i), out_valid, 1'b1);
            check($sformatf("vec_ready[%0d]", i), in_ready, 1'b1);
        end
        drive(1'b0, 3'd0, '0, '0);
        tick();
        check("idle_valid", out_valid, 1'b0);
        check("idle_out_hold", out, 16'h0000);
        check("idle_zno_hold", ZNO, 3'b101);

`ifdef ALU_MUL_EN
        mul_seq(16'h0003, 16'h0005, 16'h000F, 3'b000, 16'h0000, 3'b101, 1'b0);
        tick();
        check("mul_pulse_once", out_valid, 1'b0);
        mul_seq(16'h0100, 16'h0100, 16'h0000, 3'b101, 16'h000F, 3'b000, 1'b1);
        drive(1'b1, 3'd7, 16'h0003, 16'h0005);
        tick();
        drive(1'b0, 3'd0, '0, '0);
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midmul_rst_out", out, 16'h0000);
        check("midmul_rst_zno", ZNO, 3'b000);
        check("midmul_rst_valid", out_valid, 1'b0);
        check("midmul_rst_ready", in_ready, 1'b1);
        tick();
        reset = 1'b0;
        drive(1'b1, 3'd0, 16'h0001, 16'h0001);
        tick();
        check("after_rst_add_out", out, 16'h0002);
        check("after_rst_add_zno", ZNO, 3'b000);
        check("after_rst_add_valid", out_valid, 1'b1);
        drive(1'b0, 3'd0, '0, '0);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check($sformatf("discarded_mul_valid[%0d]", i), out_valid, 1'b0);
        end
`else
        drive(1'b1, 3'd0, 16'h0001, 16'h0001);
        tick();
        check("add11_out", out, 16'h0002);
        check("add11_zno", ZNO, 3'b000);
        drive(1'b1, 3'd7, 16'h1234, 16'h5678);
        tick();
        check("op7_out", out, 16'h0000);
        check("op7_zno", ZNO, 3'b100);
        check("op7_valid", out_valid, 1'b1);
        check("op7_ready", in_ready, 1'b1);
        drive(1'b0, 3'd0, '0, '0);
        tick();
        check("op7_pulse_once", out_valid, 1'b0);
`endif

        #2 reset = 1'b1;
        #1 reset = 1'b0;
        mul_left = 0;
        m_out = '0;
        m_zno = 3'b000;
        m_vld = 1'b0;
        pend_out = '0;
        pend_zno = 3'b000;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  W'($urandom), W'($urandom));
            if ($urandom_range(0, 7) == 0) Ain = 16'h8000;
            if ($urandom_range(0, 7) == 0) Bin = 16'h7FFF;
            m_vld = 1'b0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    m_out = pend_out;
                    m_zno = pend_zno;
                    m_vld = 1'b1;
                end
            end else if (in_valid) begin
`ifdef ALU_MUL_EN
                if (op == 3'd7) begin
                    p = {{W{1'b0}}, Ain} * {{W{1'b0}}, Bin};
                    pend_out = p[W-1:0];
                    pend_zno = {p[W-1:0] == '0, p[W-1], p[2*W-1:W] != '0};
                    mul_left = W;
                end else
`endif
                begin
                    r = ref_alu(op, Ain, Bin);
                    m_out = r[W+2:3];
                    m_zno = r[2:0];
                    m_vld = 1'b1;
                end
            end
            tick();
            check($sformatf("rnd_valid[%0d]", c), out_valid, m_vld);
            check($sformatf("rnd_out[%0d]", c), out, m_out);
            check($sformatf("rnd_zno[%0d]", c), ZNO, m_zno);
            check($sformatf("rnd_ready[%0d]", c), in_ready, mul_left == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
